// File: rtl/gray_conv_arbiter_if.sv
// Request/result bundle for gray_conv_arbiter. The arbiter takes the slave side;
// requesters and the result consumer drive the master side.
interface gray_conv_arbiter_if #(
  parameter int WIDTH   = 3,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_mode;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_mode;
  logic [ID_W-1:0]          out_id;
  logic                     out_ready;

  modport master (
    output req_valid, req_mode, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_mode, out_id
  );

  modport slave (
    input  req_valid, req_mode, req_data, out_ready,
    output req_ready, out_valid, out_data, out_mode, out_id
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared binary<->Gray converter with a 1-deep registered result slot.
// Optional GRAY_CONV_ARB_STATS_EN adds conv_count and stall_flag outputs.
//
// state      | meaning
// SLOT_EMPTY | no result held, out_valid=0
// SLOT_FULL  | result held until out_ready, out_valid=1
module gray_conv_arbiter #(
  parameter int WIDTH   = 3,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_conv_arbiter_if.slave   bus
`ifdef GRAY_CONV_ARB_STATS_EN
  ,
  output logic [15:0]          conv_count,
  output logic [0:0]           stall_flag
`endif
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t      slot_q, slot_d;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_hit;
  logic [NUM_REQ-1:0] grant;
  logic             slot_free;
  logic [WIDTH-1:0] sel_data;
  logic             sel_mode;
  logic [WIDTH-1:0] conv_data;
  logic [WIDTH-1:0] data_q;
  logic             mode_q;
  logic [ID_W-1:0]  id_q;

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = WIDTH-2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  assign slot_free = (slot_q == SLOT_EMPTY) || bus.out_ready;

  // Scan from rr_ptr with wrap; first valid requester wins. Held off during reset.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    grant_hit = 1'b0;
    idx       = '0;
    if (!rst && slot_free) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (!grant_hit && bus.req_valid[idx]) begin
          grant_hit  = 1'b1;
          grant_idx  = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign sel_data  = bus.req_data[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_mode  = bus.req_mode[grant_idx];
  assign conv_data = sel_mode ? gray_to_bin(sel_data) : bin_to_gray(sel_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= SLOT_EMPTY;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY: if (grant_hit) slot_d = SLOT_FULL;
      SLOT_FULL: begin
        if (grant_hit) begin
          slot_d = SLOT_FULL;
        end else if (bus.out_ready) begin
          slot_d = SLOT_EMPTY;
        end
      end
      default: slot_d = SLOT_EMPTY;
    endcase
  end

  // Payload holds its last value after a drain; only out_valid clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      mode_q <= 1'b0;
      id_q   <= '0;
    end else if (grant_hit) begin
      data_q <= conv_data;
      mode_q <= sel_mode;
      id_q   <= grant_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_hit) begin
      if (grant_idx == ID_W'(NUM_REQ-1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= grant_idx + ID_W'(1);
      end
    end
  end

  assign bus.out_valid = (slot_q == SLOT_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_mode  = mode_q;
  assign bus.out_id    = id_q;

`ifdef GRAY_CONV_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_count <= '0;
    end else if (grant_hit && (conv_count != 16'hFFFF)) begin
      conv_count <= conv_count + 16'd1;
    end
  end

  assign stall_flag[0] = bus.out_valid && !bus.out_ready && (|bus.req_valid);
`endif

endmodule
